multicycle_controller: RTL

Main control FSM for the multi-cycle MIPS datapath. It sequences one shared memory port, the instruction register, the register file, the ALU and the PC through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK steps. It stalls on a memory ready handshake and keeps a retired-instruction count. It sits between the instruction register fields (opcode/funct) and every datapath enable and mux select.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle MIPS controller and its datapath.
// The controller side is master: it reads the IR fields and the memory handshake and drives every enable and select.
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_op;
    logic       lu_op;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, branch_ne, pc_source, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, lu_op
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, branch_ne, pc_source, iord,
               mem_read, mem_write, ir_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, ext_op, lu_op
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath, with memory-ready stalls,
// a sticky illegal-instruction flag and a retired-instruction counter.
//  state    | meaning
//  INIT     | post-reset idle cycle, all outputs 0
//  FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
//  DECODE   | dispatch on opcode/funct, precompute branch target
//  MEM_ADDR | compute lw/sw effective address
//  MEM_RD   | data read, waits for mem_ready
//  MEM_WB   | MDR to rt
//  MEM_WR   | data write, waits for mem_ready
//  R_EXEC   | R-type ALU operation
//  R_WB     | ALUOut to rd
//  I_EXEC   | I-type ALU operation
//  I_WB     | ALUOut to rt
//  BRANCH   | beq/bne compare and conditional PC load
//  JUMP     | j/jal
//  JREG     | jr/jalr
module multicycle_controller (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus,
    output logic                           illegal,
    output logic [3:0]                     state_dbg,
    output logic [31:0]                    retired
);
    typedef enum logic [3:0] {
        S_INIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
        S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7,
        S_R_WB = 4'd8, S_I_EXEC = 4'd9, S_I_WB = 4'd10, S_BRANCH = 4'd11,
        S_JUMP = 4'd12, S_JREG = 4'd13
    } state_t;

    state_t state, next_state;
    logic   retire, set_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_INIT;
            retired <= 32'd0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (retire)
                retired <= retired + 32'd1;
            if (set_illegal)
                illegal <= 1'b1;
        end
    end

    assign state_dbg = state;

    always_comb begin
        next_state        = state;
        retire            = 1'b0;
        set_illegal       = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch_ne     = 1'b0;
        bus.pc_source     = 2'b00;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.ext_op        = 1'b0;
        bus.lu_op         = 1'b0;
        case (state)
            S_INIT: next_state = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.ext_op    = 1'b1;
                case (bus.opcode)
                    6'h23, 6'h2b: next_state = S_MEM_ADDR;
                    6'h00: next_state = (bus.funct == 6'h08 || bus.funct == 6'h09) ? S_JREG : S_R_EXEC;
                    6'h08, 6'h09, 6'h0a, 6'h0b,
                    6'h0c, 6'h0d, 6'h0f: next_state = S_I_EXEC;
                    6'h04, 6'h05: next_state = S_BRANCH;
                    6'h02, 6'h03: next_state = S_JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.ext_op    = 1'b1;
                next_state    = (bus.opcode == 6'h2b) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                if (bus.mem_ready)
                    next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
                retire         = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_R_EXEC: begin
                // shifts take shamt on port A instead of rs
                bus.alu_src_a = (bus.funct == 6'h00 || bus.funct == 6'h02 ||
                                 bus.funct == 6'h03) ? 2'b10 : 2'b01;
                bus.alu_op    = 2'b10;
                next_state    = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 2'b01;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_I_EXEC: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.alu_op    = 2'b11;
                bus.ext_op    = !(bus.opcode == 6'h0c || bus.opcode == 6'h0d);
                bus.lu_op     = (bus.opcode == 6'h0f);
                next_state    = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                next_state    = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 2'b01;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = 2'b01;
                bus.branch_ne     = (bus.opcode == 6'h05);
                retire            = 1'b1;
                next_state        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b10;
                if (bus.opcode == 6'h03) begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 2'b10;
                    bus.mem_to_reg = 2'b10;
                end
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JREG: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = 2'b11;
                if (bus.funct == 6'h09) begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 2'b01;
                    bus.mem_to_reg = 2'b10;
                end
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_INIT;
        endcase
    end
endmodule
